// File: rtl/bias_fetch.sv
// -----------------------------------------------------------------------------
// bias_fetch
//
// Read-side sequencer for the bias memory. When the layer controller requests a
// layer, the block walks that layer's bias addresses, registers each word
// returned by the memory's combinational read port and hands it to the neuron
// accumulator over a valid/ready handshake, tagged with the neuron index and a
// last-word flag.
//
// Ports
//   Clock       in   system clock, rising edge
//   Res         in   asynchronous active-low reset
//   Start       in   fetch request, sampled only while idle
//   Layer_sel   in   layer to fetch (0 = layer 1 .. 7 = layer 8)
//   mem_out     in   bias word for the address on Addr_mem_b
//   Ready_out   in   accumulator can accept Bias_out
//   Addr_mem_b  out  bias memory read address (registered)
//   Bias_out    out  bias word, passed through bit-exact (registered)
//   Bias_valid  out  Bias_out holds a word awaiting handshake
//   Neuron_idx  out  neuron index of the word on Bias_out
//   Bias_last   out  word on Bias_out is the layer's final bias
//   Busy        out  high whenever a fetch is in progress
//   Done        out  one-cycle pulse after the final handshake
// -----------------------------------------------------------------------------
module bias_fetch #(
    parameter int N_ADDR = 19
) (
    input  logic                        Clock,
    input  logic                        Res,
    input  logic                        Start,
    input  logic [2:0]                  Layer_sel,
    input  logic [31:0]                 mem_out,
    input  logic                        Ready_out,
    output logic [$clog2(N_ADDR)-1:0]   Addr_mem_b,
    output logic [31:0]                 Bias_out,
    output logic                        Bias_valid,
    output logic [1:0]                  Neuron_idx,
    output logic                        Bias_last,
    output logic                        Busy,
    output logic                        Done
);

    localparam int AW = $clog2(N_ADDR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic [31:0]     bias_q,  bias_d;
    logic            valid_q, valid_d;
    logic [1:0]      idx_q,   idx_d;
    logic            last_q,  last_d;
    logic [2:0]      count_q, count_d;   // words in the latched layer (1..4)
    logic [1:0]      cnt_q,   cnt_d;     // neuron counter within the layer

    logic [AW-1:0]   sel_base;
    logic [2:0]      sel_count;

    // Constant layer table: first bias address and number of neurons.
    always_comb begin
        // NOTE: every combinational output gets a value before the case so no
        // path leaves it unassigned, which would otherwise infer a latch.
        sel_base  = '0;
        sel_count = 3'd1;
        case (Layer_sel)
            3'd0: begin sel_base = AW'(0);  sel_count = 3'd4; end
            3'd1: begin sel_base = AW'(4);  sel_count = 3'd2; end
            3'd2: begin sel_base = AW'(6);  sel_count = 3'd1; end
            3'd3: begin sel_base = AW'(7);  sel_count = 3'd1; end
            3'd4: begin sel_base = AW'(8);  sel_count = 3'd1; end
            3'd5: begin sel_base = AW'(9);  sel_count = 3'd2; end
            3'd6: begin sel_base = AW'(11); sel_count = 3'd4; end
            3'd7: begin sel_base = AW'(15); sel_count = 3'd4; end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clock or negedge Res) begin
        if (!Res) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            bias_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            addr_q  <= addr_d;
            bias_q  <= bias_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (Start) state_d = S_FETCH;
            S_FETCH: state_d = S_HOLD;
            S_HOLD:  if (Ready_out) state_d = last_q ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
        endcase
    end

    // Datapath updates per state.
    always_comb begin
        addr_d  = addr_q;
        bias_d  = bias_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        last_d  = last_q;
        count_d = count_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                // Layer_sel is consumed only here, so later changes cannot
                // disturb a fetch already under way.
                if (Start) begin
                    addr_d  = sel_base;
                    count_d = sel_count;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                // Memory read port is combinational: mem_out already reflects
                // addr_q, so it is captured in the same cycle.
                bias_d  = mem_out;
                idx_d   = cnt_q;
                last_d  = ({1'b0, cnt_q} == (count_q - 3'd1));
                valid_d = 1'b1;
            end
            S_HOLD: begin
                if (Ready_out) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        // Address stays on the final word of the layer.
                        last_d = 1'b0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
            end
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        Busy = (state_q != S_IDLE);
        Done = (state_q == S_DONE);
    end

    assign Addr_mem_b = addr_q;
    assign Bias_out   = bias_q;
    assign Bias_valid = valid_q;
    assign Neuron_idx = idx_q;
    assign Bias_last  = last_q;

endmodule

// File: doc/bias_fetch.md
# bias_fetch

Sequencer on the read side of the bias memory. On a start request it walks the bias addresses for one selected layer (1–8) and drives `Addr_mem_b`. It registers each returned `mem_out` word and delivers it to the neuron accumulator over a valid/ready handshake, tagged with neuron index and last flag. It sits between the layer controller (`Start`/`Layer_sel`/`Done`) and the bias memory's combinational read port.

## Interface
- `N_ADDR`, 19, number of bias words in the bias memory (addresses 0..18).
- `Clock`  in  1  system clock; all state updates on the rising edge.
- `Res`  in  1  reset, asynchronous, active-low.
- `Start`  in  1  request fetch of one layer; sampled only in IDLE.
- `Layer_sel`  in  3  layer to fetch: 0 = layer 1 … 7 = layer 8; latched when `Start` is accepted.
- `mem_out`  in  32  bias word returned combinationally by bias memory for `Addr_mem_b`.
- `Ready_out`  in  1  accumulator can accept `Bias_out`.
- `Addr_mem_b`  out  5  bias memory read address (registered).
- `Bias_out`  out  32  signed bias word (registered).
- `Bias_valid`  out  1  `Bias_out` holds a valid word.
- `Neuron_idx`  out  2  neuron index within the layer of the word on `Bias_out`.
- `Bias_last`  out  1  word on `Bias_out` is the layer's final bias; qualified by `Bias_valid`.
- `Busy`  out  1  high in every state except IDLE.
- `Done`  out  1  one-cycle pulse after the final handshake.

## Operation
- Layer table (base, count):
  - L1 (0,4), L2 (4,2), L3 (6,1), L4 (7,1), L5 (8,1), L6 (9,2), L7 (11,4), L8 (15,4).
  - Implemented as constant decode.
  - Base+count−1 never exceeds `N_ADDR`−1 = 18.
- States: IDLE, FETCH, HOLD, DONE.
- IDLE:
  - `Start`=1 → FETCH.
  - Latch the layer's count, `Addr_mem_b`←base, neuron counter←0.
  - `Start`=0 → stay.
- FETCH:
  - `Bias_out`←`mem_out` (current `Addr_mem_b`).
  - `Neuron_idx`←counter.
  - `Bias_last`←(counter==count−1).
  - `Bias_valid`←1.
  - → HOLD.
- HOLD:
  - `Ready_out`=0 → stay; `Bias_out`/`Neuron_idx`/`Bias_last`/`Bias_valid` frozen.
  - `Ready_out`=1 and not last → `Bias_valid`←0, `Addr_mem_b`+1, counter+1, → FETCH.
  - `Ready_out`=1 and last → `Bias_valid`←0, `Bias_last`←0, → DONE.
- DONE:
  - `Done`=1 for this cycle only.
  - → IDLE unconditionally.
  - `Start` in DONE is ignored.
- `Start` while `Busy`=1 is ignored; no queuing.
- `Layer_sel` changes after acceptance have no effect on the fetch in progress.
- `Bias_out` is passed through bit-exact as a two's-complement word; no arithmetic on data.
- `Addr_mem_b` keeps its last value in IDLE/DONE; it never leaves base..base+count−1 during a fetch.

## Timing
- Reset (`Res`=0, asynchronous, any state):
  - State → IDLE.
  - `Addr_mem_b`=0, `Bias_out`=0, `Bias_valid`=0, `Neuron_idx`=0, `Bias_last`=0, `Busy`=0, `Done`=0.
  - Layer/count/counter registers cleared.
- Mid-fetch reset aborts without `Done`.
- After `Res` deasserts, the first `Start` edge begins a fresh fetch.
- `Start` sampled high at edge k:
  - `Busy`=1 and `Addr_mem_b`=base after k.
  - `Bias_valid`=1 after k+1.
- Handshake completes on an edge where `Bias_valid`&`Ready_out`=1.
- `Bias_valid` is low for exactly one cycle (FETCH) between consecutive words.
- Throughput: one word per 2 cycles with `Ready_out` held high.
- Layer of count n with no stall: `Done` is high in cycle k+2n+1 (edge k = start edge); `Busy` falls after that cycle.
- `Ready_out` high while `Bias_valid`=0 has no effect.
- `Ready_out` may toggle freely; a word is never dropped or duplicated.
- Earliest next `Start` accepted: first edge after DONE.

## Test plan
- Layer 7 (`Layer_sel`=6), memory words 11..14 = 0x0000000B, 0xFFFFFFF2, 0x7FFFFFFF, 0x80000000, `Ready_out`=1:
  - `Addr_mem_b` = 11, 12, 13, 14.
  - `Bias_out` in that order with `Neuron_idx` 0..3.
  - `Bias_last` only on 0x80000000.
  - `Done` pulse at k+9.
- Layer 3 (`Layer_sel`=2), word 6 = 0xFFFFFFFF:
  - Single word, `Addr_mem_b`=6.
  - `Bias_valid` and `Bias_last` together.
  - `Done` at k+3.
- Layer 2 with `Ready_out` low for 5 cycles on word 0 (value 0x12345678):
  - `Bias_out`=0x12345678, `Neuron_idx`=0, `Bias_valid`=1 held steady for 6 cycles.
  - Word 5 follows; exactly 2 handshakes.
- Layer 8, `Res` pulsed low asynchronously (mid-cycle) while in HOLD on neuron 2:
  - All outputs 0 immediately.
  - No `Done`.
  - Subsequent `Start` with layer 1 fetches addresses 0..3 correctly.
- `Start` held high through an entire layer 6 fetch, `Layer_sel` changed to 0 mid-fetch:
  - Only addresses 9, 10 fetched.
  - New fetch of layer 1 begins the cycle after `Done` (IDLE re-entry).
- All 8 layers back-to-back with random `Ready_out`:
  - Scoreboard confirms 19 words, addresses 0..18, each exactly once.
